// File: rtl/note_player_pkg.sv
// Shared types and script-style generated constants for note_player.
// STEP_TABLE / SINE_QTR are built at elaboration from integer-only arithmetic so any tool can fold them.
package note_player_pkg;

  typedef enum logic {IDLE, PLAYING} state_t;

  localparam logic [5:0] NOTE_REST    = 6'd0;
  localparam logic [5:0] NOTE_A4      = 6'd49;
  localparam int         DEF_PHASE_W  = 22;
  localparam int         DEF_SAMPLE_W = 16;
  localparam longint     SAMPLE_RATE  = 48000;

  typedef logic [63:0][31:0]  step_table_t;
  typedef logic [255:0][31:0] sine_table_t;

  // 2^(k/12) in Q30, one octave of equal-tempered ratios.
  function automatic longint semitone_ratio_q30(int k);
    case (k)
      1:       return 64'd1137589835;
      2:       return 64'd1205234448;
      3:       return 64'd1276901417;
      4:       return 64'd1352829926;
      5:       return 64'd1433273380;
      6:       return 64'd1518500250;
      7:       return 64'd1608794974;
      8:       return 64'd1704458901;
      9:       return 64'd1805811301;
      10:      return 64'd1913190429;
      11:      return 64'd2026954652;
      default: return 64'd1073741824;
    endcase
  endfunction

  // entry n = round(440 * 2^((n-49)/12) * 2^phase_w / 48000), entry 0 = 0
  function automatic step_table_t build_step_table(int phase_w);
    step_table_t t;
    longint      num;
    longint      den;
    int          d;
    int          oct;
    int          e;
    t = '0;
    for (int n = 1; n < 64; n++) begin
      d   = n - 49;
      oct = (d >= 0) ? d / 12 : -((11 - d) / 12);
      num = 64'd440 * semitone_ratio_q30(d - 12 * oct);
      den = SAMPLE_RATE;
      e   = phase_w + oct - 30;
      if (e >= 0) num = num <<< e;
      else        den = den <<< (-e);
      t[6'(n)] = 32'((num + den / 2) / den);
    end
    return t;
  endfunction

  // Quarter-wave sampled at half-step offsets so mirroring is exact.
  function automatic sine_table_t build_sine_table(int sample_w);
    sine_table_t t;
    longint      x;
    longint      x2;
    longint      term;
    longint      acc;
    longint      amp;
    t   = '0;
    amp = (64'sd1 <<< (sample_w - 1)) - 1;
    for (int i = 0; i < 256; i++) begin
      x    = (longint'(2 * i + 1) * 64'sd1686629713) / 512;
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int k = 1; k <= 6; k++) begin
        term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
        acc  = acc + term;
      end
      if (acc > (64'sd1 <<< 30)) acc = 64'sd1 <<< 30;
      if (acc < 0)               acc = 0;
      t[8'(i)] = 32'((acc * amp + (64'sd1 <<< 29)) >>> 30);
    end
    return t;
  endfunction

  localparam step_table_t STEP_TABLE = build_step_table(DEF_PHASE_W);
  localparam sine_table_t SINE_QTR   = build_sine_table(DEF_SAMPLE_W);

endpackage

// File: rtl/sine_reader.sv
// Phase-to-sample stage: quadrant mirror/negate decode, then registered quarter-wave ROM read.
// A request yields new_sample_ready exactly two cycles later; sample_out is 0 whenever not ready.
module sine_reader
  import note_player_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       request,
  input  logic                       mute,
  input  logic [9:0]                 phase_idx,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       new_sample_ready
);
  // NOTE: the ROM is a constant, not storage, so it has no reset and no write port.
  localparam sine_table_t ROM = build_sine_table(SAMPLE_W);

  logic                valid_q;
  logic                mute_q;
  logic                negate_q;
  logic [7:0]          addr_q;
  logic [SAMPLE_W-1:0] mag;

  assign mag = ROM[addr_q][SAMPLE_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q          <= 1'b0;
      mute_q           <= 1'b1;
      negate_q         <= 1'b0;
      addr_q           <= '0;
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
    end else begin
      valid_q <= request;
      if (request) begin
        addr_q   <= phase_idx[8] ? ~phase_idx[7:0] : phase_idx[7:0];
        negate_q <= phase_idx[9];
        mute_q   <= mute;
      end
      new_sample_ready <= valid_q;
      if (valid_q && !mute_q)
        sample_out <= negate_q ? -$signed(mag) : $signed(mag);
      else
        sample_out <= '0;
    end
  end

endmodule

// File: rtl/note_player.sv
// note_player: plays one note per handshake as a sine tone, counting beats until the duration expires.
// Define NOTE_PLAYER_RELOAD_EN to let a load during PLAYING preempt the current note.
module note_player
  import note_player_pkg::*;
#(
  parameter int PHASE_W  = 22,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  input  logic [5:0]                 note_to_load,
  input  logic [5:0]                 duration_to_load,
  input  logic                       load_new_note,
  input  logic                       beat,
  input  logic                       generate_next_sample,
  output logic                       player_available,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       new_sample_ready
);
  localparam step_table_t STEPS = build_step_table(PHASE_W);

  state_t             state;
  logic [5:0]         note;
  logic [5:0]         remaining;
  logic [PHASE_W-1:0] step;
  logic [PHASE_W-1:0] phase;
  logic               advance;
  logic               audible;

  assign advance = (state == PLAYING) && play_enable;
  assign audible = advance && (note != NOTE_REST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      note             <= NOTE_REST;
      remaining        <= '0;
      step             <= '0;
      phase            <= '0;
      player_available <= 1'b1;
    end else begin
      // NOTE: non-blocking updates; a load later in this block overrides the phase advance.
      if (generate_next_sample && advance)
        phase <= phase + step;

      case (state)
        IDLE: begin
          if (load_new_note) begin
            note      <= note_to_load;
            remaining <= duration_to_load;
            step      <= PHASE_W'(STEPS[note_to_load]);
            phase     <= '0;
            if (duration_to_load != 6'd0) begin
              state            <= PLAYING;
              player_available <= 1'b0;
            end
          end
        end
        PLAYING: begin
`ifdef NOTE_PLAYER_RELOAD_EN
          if (load_new_note) begin
            note      <= note_to_load;
            remaining <= duration_to_load;
            step      <= PHASE_W'(STEPS[note_to_load]);
            phase     <= '0;
            if (duration_to_load == 6'd0) begin
              state            <= IDLE;
              player_available <= 1'b1;
            end
          end else
`endif
          if (beat && play_enable) begin
            remaining <= remaining - 6'd1;
            if (remaining == 6'd1) begin
              state            <= IDLE;
              player_available <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sine_reader #(
    .SAMPLE_W(SAMPLE_W)
  ) u_sine_reader (
    .clk              (clk),
    .reset            (reset),
    .request          (generate_next_sample),
    .mute             (!audible),
    .phase_idx        (phase[PHASE_W-1 -: 10]),
    .sample_out       (sample_out),
    .new_sample_ready (new_sample_ready)
  );

endmodule
